fsrc_seq_engine: RTL and testbench

//  Parametrised FSRC sequencer: after a start event, counts sysref_int pulses and fires NUM_TRIG

---
 rtl/fsrc_seq_engine.sv | 178 +++++++++++++++++
 tb/tb_fsrc_seq_engine.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsrc_seq_engine.sv
// fsrc_seq_engine: FSRC sequencer. After a start event it counts sysref_int
// pulses and fires NUM_TRIG masked, width-programmable trigger pulses plus a
// tx_data_start/done pulse when the count reaches end_cnt. All run
// configuration is shadowed when the first sysref after arming arrives.
// Optional feature macro: FSRC_SEQ_CTRL_EN (registered ctrl word update at
// ctrl_change_cnt). Without it ctrl is tied to zero.
module fsrc_seq_engine #(
  parameter int COUNTER_WIDTH = 8,
  parameter int NUM_TRIG      = 4,
  parameter int PW_WIDTH      = 4,
  parameter int CTRL_WIDTH    = 40
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              sysref_int,
  input  logic                              reg_start,
  input  logic                              seq_trig_in,
  input  logic                              seq_ext_trig_en,
  input  logic                              abort,
  input  logic [NUM_TRIG-1:0]               trig_en,
  input  logic [NUM_TRIG*COUNTER_WIDTH-1:0] trig_cnt,
  input  logic [NUM_TRIG*PW_WIDTH-1:0]      trig_width,
  input  logic [COUNTER_WIDTH-1:0]          end_cnt,
  input  logic [CTRL_WIDTH-1:0]             next_ctrl_value,
  input  logic [COUNTER_WIDTH-1:0]          ctrl_change_cnt,
  output logic [NUM_TRIG-1:0]               trig_out,
  output logic                              tx_data_start,
  output logic                              busy,
  output logic                              done,
  output logic [CTRL_WIDTH-1:0]             ctrl
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t                     state_q;
  state_t                     state_d;
  logic                       seq_trig_in_d;
  logic                       start;
  logic [COUNTER_WIDTH-1:0]   count;

  // Shadowed run configuration
  logic [NUM_TRIG-1:0]        sh_en;
  logic [COUNTER_WIDTH-1:0]   sh_cnt [NUM_TRIG];
  logic [PW_WIDTH-1:0]        sh_width [NUM_TRIG];
  logic [COUNTER_WIDTH-1:0]   sh_end;

  // Per-trigger remaining stretch cycles
  logic [PW_WIDTH-1:0]        wcnt [NUM_TRIG];

  logic                       arm_hit;
  logic                       run_hit;
  logic                       end_hit;
  logic                       kill;
  logic [NUM_TRIG-1:0]        fire;

  assign start   = seq_ext_trig_en ? (seq_trig_in & ~seq_trig_in_d) : reg_start;
  // Abort always takes priority over any sysref-driven action in the same cycle.
  assign arm_hit = (state_q == ARMED) && sysref_int && !abort;
  assign run_hit = (state_q == RUN) && sysref_int && !abort;
  assign end_hit = run_hit && (count == sh_end);
  assign kill    = abort && (state_q != IDLE);

  // Trigger match: compare the pre-increment count against each shadow.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    fire = '0;
    for (int i = 0; i < NUM_TRIG; i++) begin
      fire[i] = run_hit && sh_en[i] && (count == sh_cnt[i]);
    end
  end

  // Next-state logic for the IDLE/ARMED/RUN sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && !abort) state_d = ARMED;
      ARMED: begin
        if (abort)           state_d = IDLE;
        else if (sysref_int) state_d = RUN;
      end
      RUN:     if (abort || end_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, start edge detector and registered status pulses.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q       <= IDLE;
      seq_trig_in_d <= 1'b0;
      busy          <= 1'b0;
      tx_data_start <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      seq_trig_in_d <= seq_trig_in;
      busy          <= (state_d != IDLE);
      tx_data_start <= end_hit;
      done          <= end_hit;
    end
  end

  // Sysref event counter and configuration shadow capture at run entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      sh_en  <= '0;
      sh_end <= '0;
      // NOTE: these small shadow arrays are reset explicitly so no X can reach
      // the comparators; large storage arrays would normally be left unreset.
      for (int i = 0; i < NUM_TRIG; i++) begin
        sh_cnt[i]   <= '0;
        sh_width[i] <= '0;
      end
    end else if (arm_hit) begin
      count  <= '0;
      sh_en  <= trig_en;
      sh_end <= end_cnt;
      for (int i = 0; i < NUM_TRIG; i++) begin
        sh_cnt[i]   <= trig_cnt[i*COUNTER_WIDTH +: COUNTER_WIDTH];
        sh_width[i] <= trig_width[i*PW_WIDTH +: PW_WIDTH];
      end
    end else if (run_hit && !end_hit) begin
      count <= count + 1'b1;
    end
  end

  // Trigger pulse stretchers: a match (re)loads the width; abort clears all.
  always_ff @(posedge clk) begin
    if (reset || kill) begin
      trig_out <= '0;
      for (int i = 0; i < NUM_TRIG; i++) wcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_TRIG; i++) begin
        if (fire[i]) begin
          trig_out[i] <= 1'b1;
          wcnt[i]     <= sh_width[i];
        end else if (trig_out[i]) begin
          if (wcnt[i] == '0) trig_out[i] <= 1'b0;
          else               wcnt[i]     <= wcnt[i] - 1'b1;
        end
      end
    end
  end

`ifdef FSRC_SEQ_CTRL_EN
  logic [CTRL_WIDTH-1:0]    sh_next_ctrl;
  logic [COUNTER_WIDTH-1:0] sh_ctrl_cnt;

  // Control word: shadowed at run entry, applied at ctrl_change_cnt, held across runs.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl         <= '0;
      sh_next_ctrl <= '0;
      sh_ctrl_cnt  <= '0;
    end else begin
      if (arm_hit) begin
        sh_next_ctrl <= next_ctrl_value;
        sh_ctrl_cnt  <= ctrl_change_cnt;
      end
      if (run_hit && (count == sh_ctrl_cnt)) ctrl <= sh_next_ctrl;
    end
  end
`else
  logic unused_ctrl_inputs;

  assign unused_ctrl_inputs = ^{next_ctrl_value, ctrl_change_cnt};
  assign ctrl               = '0;
`endif

endmodule

// File: tb/tb_fsrc_seq_engine.sv
// tb_fsrc_seq_engine: table-driven runs, directed corner sequences and random
// stimulus, all compared every cycle against a behavioural run-level model.
module tb_fsrc_seq_engine;

  localparam int CW  = 8;
  localparam int NT  = 4;
  localparam int PW  = 4;
  localparam int CTW = 40;

  logic            clk = 1'b0;
  logic            reset;
  logic            sysref_int;
  logic            reg_start;
  logic            seq_trig_in;
  logic            seq_ext_trig_en;
  logic            abort;
  logic [NT-1:0]   trig_en;
  logic [NT*CW-1:0] trig_cnt;
  logic [NT*PW-1:0] trig_width;
  logic [CW-1:0]   end_cnt;
  logic [CTW-1:0]  next_ctrl_value;
  logic [CW-1:0]   ctrl_change_cnt;
  logic [NT-1:0]   trig_out;
  logic            tx_data_start;
  logic            busy;
  logic            done;
  logic [CTW-1:0]  ctrl;

  always #5 clk = ~clk;

  fsrc_seq_engine #(
    .COUNTER_WIDTH (CW),
    .NUM_TRIG      (NT),
    .PW_WIDTH      (PW),
    .CTRL_WIDTH    (CTW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .sysref_int      (sysref_int),
    .reg_start       (reg_start),
    .seq_trig_in     (seq_trig_in),
    .seq_ext_trig_en (seq_ext_trig_en),
    .abort           (abort),
    .trig_en         (trig_en),
    .trig_cnt        (trig_cnt),
    .trig_width      (trig_width),
    .end_cnt         (end_cnt),
    .next_ctrl_value (next_ctrl_value),
    .ctrl_change_cnt (ctrl_change_cnt),
    .trig_out        (trig_out),
    .tx_data_start   (tx_data_start),
    .busy            (busy),
    .done            (done),
    .ctrl            (ctrl)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: run phase, event count, shadows, remaining high cycles.
  int             m_phase;   // 0 idle, 1 armed, 2 running
  int             m_count;
  bit             m_prev_in;
  bit             m_tx;
  bit             m_done;
  int             m_rem  [NT];
  bit             s_en   [NT];
  int             s_cnt  [NT];
  int             s_w    [NT];
  int             s_end;
  logic [CTW-1:0] m_ctrl;
  logic [CTW-1:0] s_nctrl;
  int             s_ccnt;

  // Observation counters for the directed/table checks
  int hi_cnt [NT];
  int done_cnt;
  int tx_cnt;
  int sr_ctr;
  int sr_period;
  int sr_seen;
  int rise_at;
  bit prev_t0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit st;
    if (reset) begin
      m_phase = 0; m_count = 0; m_prev_in = 0; m_tx = 0; m_done = 0; m_ctrl = '0;
      for (int i = 0; i < NT; i++) m_rem[i] = 0;
      return;
    end
    st = seq_ext_trig_en ? (seq_trig_in && !m_prev_in) : reg_start;
    m_prev_in = seq_trig_in;
    m_tx = 0;
    m_done = 0;
    for (int i = 0; i < NT; i++) if (m_rem[i] > 0) m_rem[i]--;
    case (m_phase)
      0: if (st && !abort) m_phase = 1;
      1: begin
        if (abort) begin
          m_phase = 0;
          for (int i = 0; i < NT; i++) m_rem[i] = 0;
        end else if (sysref_int) begin
          m_phase = 2;
          m_count = 0;
          for (int i = 0; i < NT; i++) begin
            s_en[i]  = trig_en[i];
            s_cnt[i] = int'(trig_cnt[i*CW +: CW]);
            s_w[i]   = int'(trig_width[i*PW +: PW]);
          end
          s_end   = int'(end_cnt);
          s_nctrl = next_ctrl_value;
          s_ccnt  = int'(ctrl_change_cnt);
        end
      end
      default: begin
        if (abort) begin
          m_phase = 0;
          for (int i = 0; i < NT; i++) m_rem[i] = 0;
        end else if (sysref_int) begin
          for (int i = 0; i < NT; i++)
            if (s_en[i] && m_count == s_cnt[i]) m_rem[i] = s_w[i] + 1;
`ifdef FSRC_SEQ_CTRL_EN
          if (m_count == s_ccnt) m_ctrl = s_nctrl;
`endif
          if (m_count == s_end) begin
            m_tx = 1; m_done = 1; m_phase = 0;
          end else begin
            m_count++;
          end
        end
      end
    endcase
  endtask

  // One clock: model follows the same sampled inputs; outputs compared 1 time unit later.
  task automatic tick();
    logic [NT-1:0] mt;
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < NT; i++) mt[i] = (m_rem[i] > 0);
    check("trig_out", 64'(trig_out), 64'(mt));
    check("tx_data_start", 64'(tx_data_start), 64'(m_tx));
    check("done", 64'(done), 64'(m_done));
    check("busy", 64'(busy), 64'(m_phase != 0));
    check("ctrl", 64'(ctrl), 64'(m_ctrl));
    for (int i = 0; i < NT; i++) hi_cnt[i] += int'(trig_out[i]);
    done_cnt += int'(done);
    tx_cnt   += int'(tx_data_start);
  endtask

  // One clock with a periodic sysref strobe.
  task automatic cyc();
    sysref_int = (sr_ctr == 0);
    if (sysref_int) sr_seen++;
    tick();
    sysref_int = 1'b0;
    sr_ctr = (sr_ctr + 1) % sr_period;
    if (trig_out[0] && !prev_t0 && rise_at < 0) rise_at = sr_seen;
    prev_t0 = trig_out[0];
  endtask

  task automatic clear_obs();
    for (int i = 0; i < NT; i++) hi_cnt[i] = 0;
    done_cnt = 0; tx_cnt = 0; sr_seen = 0; rise_at = -1; prev_t0 = trig_out[0];
  endtask

  task automatic start_run();
    clear_obs();
    sr_ctr = 1;
    reg_start = 1'b1;
    cyc();
    reg_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int budget = 3000;
    while (done_cnt == 0 && budget > 0) begin
      cyc();
      budget--;
    end
    if (budget == 0) check({name, "_timeout"}, 64'(done_cnt), 64'd1);
  endtask

  typedef struct packed {
    logic [NT-1:0]    en;
    logic [NT*CW-1:0] cnt;
    logic [NT*PW-1:0] w;
    logic [CW-1:0]    endc;
    logic [NT*8-1:0]  exp_hi;
  } vec_t;

  vec_t vecs [6];

  initial begin
    // {en, cnt{3,2,1,0}, width{3,2,1,0}, end_cnt, expected high cycles{3,2,1,0}}
    vecs[0] = '{4'b0001, {8'd0, 8'd0, 8'd0, 8'd2},     {4'd0, 4'd0, 4'd0, 4'd3},   8'd5,   {8'd0, 8'd0, 8'd0, 8'd4}};
    vecs[1] = '{4'b1100, {8'd7, 8'd3, 8'd0, 8'd0},     {4'd2, 4'd1, 4'd0, 4'd0},   8'd3,   {8'd0, 8'd2, 8'd0, 8'd0}};
    vecs[2] = '{4'b1111, {8'd0, 8'd0, 8'd0, 8'd0},     {4'd15, 4'd2, 4'd1, 4'd0},  8'd0,   {8'd16, 8'd3, 8'd2, 8'd1}};
    vecs[3] = '{4'b0000, {8'd1, 8'd1, 8'd1, 8'd1},     {4'd1, 4'd1, 4'd1, 4'd1},   8'd2,   {8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[4] = '{4'b0010, {8'd0, 8'd0, 8'd4, 8'd0},     {4'd0, 4'd0, 4'd15, 4'd0},  8'd4,   {8'd0, 8'd0, 8'd16, 8'd0}};
    vecs[5] = '{4'b1001, {8'd0, 8'd0, 8'd0, 8'd255},   {4'd5, 4'd0, 4'd0, 4'd0},   8'd255, {8'd6, 8'd0, 8'd0, 8'd1}};

    reset = 1'b1; sysref_int = 0; reg_start = 0; seq_trig_in = 0; seq_ext_trig_en = 0; abort = 0;
    trig_en = '0; trig_cnt = '0; trig_width = '0; end_cnt = '0;
    next_ctrl_value = '0; ctrl_change_cnt = '0;
    sr_ctr = 0; sr_period = 4;
    clear_obs();
    tick(); tick();
    check("reset_trig_out", 64'(trig_out), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    reset = 1'b0;
    tick();

    // Table-driven complete runs
    for (int r = 0; r < 6; r++) begin
      trig_en = vecs[r].en; trig_cnt = vecs[r].cnt; trig_width = vecs[r].w; end_cnt = vecs[r].endc;
      start_run();
      wait_done($sformatf("row%0d", r));
      repeat (24) cyc();
      for (int i = 0; i < NT; i++)
        check($sformatf("row%0d_hi%0d", r, i), 64'(hi_cnt[i]), 64'(vecs[r].exp_hi[i*8 +: 8]));
      check($sformatf("row%0d_done", r), 64'(done_cnt), 64'd1);
      check($sformatf("row%0d_tx", r), 64'(tx_cnt), 64'd1);
    end

    // Test 1 timing: trig0 rises right after the 3rd RUN sysref (4th incl. arming)
    sr_period = 16;
    trig_en = 4'b0001; trig_cnt = {8'd0, 8'd0, 8'd0, 8'd2}; trig_width = {4'd0, 4'd0, 4'd0, 4'd3}; end_cnt = 8'd5;
    start_run();
    wait_done("t1");
    check("t1_rise_sysref", 64'(rise_at), 64'd4);
    check("t1_done_sysref", 64'(sr_seen), 64'd7);
    check("t1_hi", 64'(hi_cnt[0]), 64'd4);
    repeat (8) cyc();

    // External start: held level gives one run, reg_start ignored
    sr_period = 4;
    seq_ext_trig_en = 1'b1; end_cnt = 8'd2;
    clear_obs();
    seq_trig_in = 1'b1;
    for (int c = 0; c < 10; c++) begin
      reg_start = (c == 5);
      cyc();
    end
    reg_start = 1'b0; seq_trig_in = 1'b0;
    for (int c = 0; c < 40; c++) begin
      reg_start = (c == 30);
      cyc();
    end
    reg_start = 1'b0;
    check("ext_one_run", 64'(done_cnt), 64'd1);
    check("ext_idle", 64'(busy), 64'd0);
    seq_ext_trig_en = 1'b0;

    // Abort and start together while idle: abort wins
    reg_start = 1'b1; abort = 1'b1;
    cyc();
    reg_start = 1'b0; abort = 1'b0;
    check("abort_start_idle", 64'(busy), 64'd0);

    // Abort mid-stretch two clocks after the 2nd RUN sysref
    sr_period = 8;
    trig_en = 4'b0010; trig_cnt = {8'd0, 8'd0, 8'd1, 8'd0}; trig_width = {4'd0, 4'd0, 4'd7, 4'd0}; end_cnt = 8'd5;
    start_run();
    while (sr_seen < 3) cyc();
    cyc();
    check("abort_pre_trig", 64'(trig_out[1]), 64'd1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("abort_trig_cleared", 64'(trig_out), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    repeat (60) cyc();
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_no_tx", 64'(tx_cnt), 64'd0);

    // Mid-run config change is shadowed; start while busy ignored
    sr_period = 6;
    trig_en = 4'b0001; trig_cnt = {8'd0, 8'd0, 8'd0, 8'd1}; trig_width = '0; end_cnt = 8'd5;
    start_run();
    while (sr_seen < 2) cyc();
    trig_cnt = {8'd0, 8'd0, 8'd0, 8'd4};
    reg_start = 1'b1;
    cyc();
    reg_start = 1'b0;
    wait_done("shadow1");
    check("shadow1_rise", 64'(rise_at), 64'd3);
    repeat (20) cyc();
    check("shadow1_single_run", 64'(done_cnt), 64'd1);
    start_run();
    wait_done("shadow2");
    check("shadow2_rise", 64'(rise_at), 64'd6);

    // Control word update at ctrl_change_cnt
    next_ctrl_value = 40'hA5; ctrl_change_cnt = 8'd1; end_cnt = 8'd3;
    start_run();
    wait_done("ctrl");
`ifdef FSRC_SEQ_CTRL_EN
    check("ctrl_value", 64'(ctrl), 64'hA5);
`else
    check("ctrl_value", 64'(ctrl), 64'h0);
`endif
    repeat (8) cyc();

    // Reset in the middle of a run
    end_cnt = 8'd50; trig_en = 4'b0001; trig_cnt = '0; trig_width = {4'd0, 4'd0, 4'd0, 4'd15};
    start_run();
    while (sr_seen < 2) cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_trig", 64'(trig_out), 64'd0);

    // Random stimulus against the model
    for (int c = 0; c < 4000; c++) begin
      sysref_int      = ($urandom_range(0, 3) == 0);
      reg_start       = ($urandom_range(0, 19) == 0);
      abort           = ($urandom_range(0, 149) == 0);
      seq_trig_in     = ($urandom_range(0, 9) == 0) ? ~seq_trig_in : seq_trig_in;
      if ($urandom_range(0, 199) == 0) seq_ext_trig_en = ~seq_ext_trig_en;
      reset           = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 29) == 0) begin
        trig_en = NT'($urandom());
        for (int i = 0; i < NT; i++) begin
          trig_cnt[i*CW +: CW]   = CW'($urandom_range(0, 12));
          trig_width[i*PW +: PW] = PW'($urandom());
        end
        end_cnt         = CW'($urandom_range(0, 10));
        next_ctrl_value = {8'($urandom()), 32'($urandom())};
        ctrl_change_cnt = CW'($urandom_range(0, 12));
      end
      tick();
    end
    sysref_int = 0; reg_start = 0; abort = 0; reset = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
